// File: rtl/alu_pkg.sv
// Shared types for the integer ALU: operator encoding and the operation bundle.
package alu_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [5:0] {
        ADD, SUB, XORL, ORL, ANDL, ANDN, ORN, XNOR,
        SLL, SRL, SRA, ROL, ROR,
        SLTS, SLTU, MAX, MAXU, MIN, MINU,
        SH1ADD, SH2ADD, SH3ADD,
        CLZ, CTZ, CPOP,
        SEXTB, SEXTH, ZEXTH, REV8, ORCB,
        EQ, NE, LTS, LTU, GES, GEU
    } fu_op_t;

    typedef struct packed {
        fu_op_t            operator;
        logic [XLEN-1:0]   operand_a;
        logic [XLEN-1:0]   operand_b;
    } fu_data_t;

endpackage

// File: rtl/alu_bitcnt.sv
// Zbb bit counting: leading zeros, trailing zeros and population count of one operand.
module alu_bitcnt #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]        a_i,
    output logic [$clog2(XLEN):0]  clz_o,
    output logic [$clog2(XLEN):0]  ctz_o,
    output logic [$clog2(XLEN):0]  cpop_o
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;

    // The highest set bit is visited last, so it decides the count; a==0 keeps XLEN.
    function automatic logic [CNT_W-1:0] lzc(input logic [XLEN-1:0] v);
        logic [CNT_W-1:0] n;
        n = CNT_W'(XLEN);
        for (int i = 0; i < XLEN; i++) begin
            if (v[i]) n = CNT_W'(XLEN - 1 - i);
        end
        return n;
    endfunction

    logic [XLEN-1:0]  a_rev;
    logic [CNT_W-1:0] pop;

    // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
    always_comb begin
        a_rev = '0;
        pop   = '0;
        for (int i = 0; i < XLEN; i++) begin
            a_rev[i] = a_i[XLEN-1-i];
            pop      = pop + CNT_W'(a_i[i]);
        end
    end

    assign clz_o  = lzc(a_i);
    assign ctz_o  = lzc(a_rev);
    assign cpop_o = pop;

endmodule

// File: rtl/int_alu.sv
// Single-cycle integer ALU (RV32I/RV64I + Zbb subset); purely combinational datapath.
module int_alu #(
    parameter int unsigned XLEN = alu_pkg::XLEN
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  alu_pkg::fu_data_t  fu_data_i,
    output logic [XLEN-1:0]    result_o,
    output logic               alu_branch_res_o
);

    import alu_pkg::*;

    localparam int unsigned SHW   = $clog2(XLEN);
    localparam int unsigned CNT_W = SHW + 1;

    fu_op_t          op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [SHW-1:0]  sh;

    assign op = fu_data_i.operator;
    assign a  = fu_data_i.operand_a;
    assign b  = fu_data_i.operand_b;
    assign sh = b[SHW-1:0];

    // Shared adder: ADD, SUB (a + ~b + 1) and the shift-add family.
    logic [XLEN-1:0] add_a;
    logic [XLEN-1:0] add_b;
    logic [XLEN-1:0] sum;
    logic            sub_en;

    always_comb begin
        add_a = a;
        case (op)
            SH1ADD:  add_a = a << 1;
            SH2ADD:  add_a = a << 2;
            SH3ADD:  add_a = a << 3;
            default: add_a = a;
        endcase
    end

    assign sub_en = (op == SUB);
    assign add_b  = sub_en ? ~b : b;
    assign sum    = add_a + add_b + XLEN'(sub_en);

    // One XLEN+1 subtractor serves every ordered compare; the extension bit selects signedness.
    logic            cmp_signed;
    logic [XLEN:0]   cmp_diff;
    logic            lt;
    logic            eq;

    always_comb begin
        cmp_signed = 1'b0;
        case (op)
            SLTS, MAX, MIN, LTS, GES: cmp_signed = 1'b1;
            default:                  cmp_signed = 1'b0;
        endcase
    end

    assign cmp_diff = {cmp_signed & a[XLEN-1], a} - {cmp_signed & b[XLEN-1], b};
    assign lt       = cmp_diff[XLEN];
    assign eq       = (a == b);

    // Rotates read the matching half of a doubled operand.
    logic [2*XLEN-1:0] rol_full;
    logic [2*XLEN-1:0] ror_full;
    logic [XLEN-1:0]   sra_res;

    assign rol_full = {a, a} << sh;
    assign ror_full = {a, a} >> sh;
    assign sra_res  = $signed(a) >>> sh;

    logic [XLEN-1:0] rev8;
    logic [XLEN-1:0] orcb;

    always_comb begin
        rev8 = '0;
        orcb = '0;
        for (int i = 0; i < XLEN / 8; i++) begin
            rev8[8*i +: 8] = a[XLEN-8-8*i +: 8];
            orcb[8*i +: 8] = {8{|a[8*i +: 8]}};
        end
    end

    logic [CNT_W-1:0] clz;
    logic [CNT_W-1:0] ctz;
    logic [CNT_W-1:0] cpop;

    alu_bitcnt #(
        .XLEN (XLEN)
    ) u_bitcnt (
        .a_i    (a),
        .clz_o  (clz),
        .ctz_o  (ctz),
        .cpop_o (cpop)
    );

    logic branch_res;

    always_comb begin
        branch_res = 1'b0;
        case (op)
            EQ:      branch_res = eq;
            NE:      branch_res = ~eq;
            LTS:     branch_res = lt;
            LTU:     branch_res = lt;
            GES:     branch_res = ~lt;
            GEU:     branch_res = ~lt;
            default: branch_res = 1'b0;
        endcase
    end

    always_comb begin
        result_o = '0;
        case (op)
            ADD, SUB, SH1ADD, SH2ADD, SH3ADD: result_o = sum;
            XORL:   result_o = a ^ b;
            ORL:    result_o = a | b;
            ANDL:   result_o = a & b;
            ANDN:   result_o = a & ~b;
            ORN:    result_o = a | ~b;
            XNOR:   result_o = ~(a ^ b);
            SLL:    result_o = a << sh;
            SRL:    result_o = a >> sh;
            SRA:    result_o = sra_res;
            ROL:    result_o = rol_full[2*XLEN-1:XLEN];
            ROR:    result_o = ror_full[XLEN-1:0];
            SLTS, SLTU: result_o = XLEN'(lt);
            MAX, MAXU:  result_o = lt ? b : a;
            MIN, MINU:  result_o = lt ? a : b;
            CLZ:    result_o = XLEN'(clz);
            CTZ:    result_o = XLEN'(ctz);
            CPOP:   result_o = XLEN'(cpop);
            SEXTB:  result_o = {{(XLEN-8){a[7]}}, a[7:0]};
            SEXTH:  result_o = {{(XLEN-16){a[15]}}, a[15:0]};
            ZEXTH:  result_o = {{(XLEN-16){1'b0}}, a[15:0]};
            REV8:   result_o = rev8;
            ORCB:   result_o = orcb;
            EQ, NE, LTS, LTU, GES, GEU: result_o = XLEN'(branch_res);
            default: result_o = '0;
        endcase
    end

    assign alu_branch_res_o = branch_res;

    // Clock, reset and the discarded halves of wide intermediates are intentionally unused.
    logic unused_ok;
    assign unused_ok = ^{clk_i, rst_i, cmp_diff[XLEN-1:0], rol_full[XLEN-1:0],
                         ror_full[2*XLEN-1:XLEN]};

endmodule

// File: tb/tb_int_alu.sv
// Self-checking bench for int_alu: directed vector table, reset sequence, random vs reference model.
module tb_int_alu;

    import alu_pkg::*;

    logic        clk;
    logic        rst;
    fu_data_t    fu_data;
    logic [31:0] result;
    logic        br;

    int n_cmp  = 0;
    int n_fail = 0;

    int_alu #(
        .XLEN (32)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .fu_data_i        (fu_data),
        .result_o         (result),
        .alu_branch_res_o (br)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        fu_op_t      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        br;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic apply(input fu_op_t op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        fu_data = '{operator: op, operand_a: a, operand_b: b};
        #1;
    endtask

    // Reference model written straight from the operator definitions.
    function automatic void model(input fu_op_t op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic bres);
        int s;
        int n;
        s    = int'(b[4:0]);
        r    = '0;
        bres = 1'b0;
        case (op)
            ADD:    r = a + b;
            SUB:    r = a - b;
            XORL:   r = a ^ b;
            ORL:    r = a | b;
            ANDL:   r = a & b;
            ANDN:   r = a & ~b;
            ORN:    r = a | ~b;
            XNOR:   r = ~(a ^ b);
            SLL:    r = a << s;
            SRL:    r = a >> s;
            SRA:    r = 32'($signed(a) >>> s);
            ROL:    for (int i = 0; i < 32; i++) r[(i + s) % 32] = a[i];
            ROR:    for (int i = 0; i < 32; i++) r[i] = a[(i + s) % 32];
            SLTS:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            SLTU:   r = (a < b) ? 32'd1 : 32'd0;
            MAX:    r = ($signed(a) >= $signed(b)) ? a : b;
            MAXU:   r = (a >= b) ? a : b;
            MIN:    r = ($signed(a) <= $signed(b)) ? a : b;
            MINU:   r = (a <= b) ? a : b;
            SH1ADD: r = a * 2 + b;
            SH2ADD: r = a * 4 + b;
            SH3ADD: r = a * 8 + b;
            CLZ: begin
                n = 0;
                while (n < 32 && !a[31-n]) n++;
                r = n;
            end
            CTZ: begin
                n = 0;
                while (n < 32 && !a[n]) n++;
                r = n;
            end
            CPOP:   r = $countones(a);
            SEXTB:  r = 32'($signed(a[7:0]));
            SEXTH:  r = 32'($signed(a[15:0]));
            ZEXTH:  r = a & 32'h0000_FFFF;
            REV8:   r = {a[7:0], a[15:8], a[23:16], a[31:24]};
            ORCB:   for (int k = 0; k < 4; k++) r[8*k +: 8] = (a[8*k +: 8] != 0) ? 8'hFF : 8'h00;
            EQ:     bres = (a == b);
            NE:     bres = (a != b);
            LTS:    bres = ($signed(a) < $signed(b));
            LTU:    bres = (a < b);
            GES:    bres = ($signed(a) >= $signed(b));
            GEU:    bres = (a >= b);
            default: r = '0;
        endcase
        if (op inside {EQ, NE, LTS, LTU, GES, GEU}) r = {31'b0, bres};
    endfunction

    vec_t vecs[$];

    initial begin
        logic [31:0] exp_r;
        logic        exp_b;
        logic [31:0] ra;
        logic [31:0] rb;
        fu_op_t      rop;

        rst     = 1'b1;
        fu_data = '{operator: ADD, operand_a: 32'd0, operand_b: 32'd0};

        vecs.push_back('{ANDL,   32'h0000_000F, 32'h0000_0000, 32'h0000_0000, 1'b0});
        vecs.push_back('{ORL,    32'h0000_000F, 32'h0000_0000, 32'h0000_000F, 1'b0});
        vecs.push_back('{XORL,   32'h0000_000F, 32'h0000_0000, 32'h0000_000F, 1'b0});
        vecs.push_back('{ANDL,   32'h0000_000F, 32'h0000_000F, 32'h0000_000F, 1'b0});
        vecs.push_back('{ORL,    32'h0000_000F, 32'h0000_000F, 32'h0000_000F, 1'b0});
        vecs.push_back('{XORL,   32'h0000_000F, 32'h0000_000F, 32'h0000_0000, 1'b0});
        vecs.push_back('{ANDN,   32'h0000_00F0, 32'h0000_003C, 32'h0000_00C0, 1'b0});
        vecs.push_back('{ORN,    32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{XNOR,   32'h0000_000F, 32'h0000_000F, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{ADD,    32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0});
        vecs.push_back('{SUB,    32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{ADD,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0});
        vecs.push_back('{SH2ADD, 32'h0000_0003, 32'h0000_0001, 32'h0000_000D, 1'b0});
        vecs.push_back('{SLL,    32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0});
        vecs.push_back('{SRL,    32'h8000_0000, 32'h0000_0001, 32'h4000_0000, 1'b0});
        vecs.push_back('{SRA,    32'h8000_0000, 32'h0000_0001, 32'hC000_0000, 1'b0});
        vecs.push_back('{SLL,    32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0});
        vecs.push_back('{ROR,    32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 1'b0});
        vecs.push_back('{ROL,    32'h8000_0001, 32'h0000_0000, 32'h8000_0001, 1'b0});
        vecs.push_back('{ROL,    32'h8000_0001, 32'h0000_0001, 32'h0000_0003, 1'b0});
        vecs.push_back('{SLTS,   32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0});
        vecs.push_back('{SLTU,   32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0000, 1'b0});
        vecs.push_back('{MAX,    32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0002, 1'b0});
        vecs.push_back('{MAXU,   32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{MIN,    32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{MINU,   32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0002, 1'b0});
        vecs.push_back('{LTS,    32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b1});
        vecs.push_back('{LTU,    32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0000, 1'b0});
        vecs.push_back('{GEU,    32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b1});
        vecs.push_back('{EQ,     32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0000, 1'b0});
        vecs.push_back('{EQ,     32'h0000_0005, 32'h0000_0005, 32'h0000_0001, 1'b1});
        vecs.push_back('{NE,     32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0});
        vecs.push_back('{ADD,    32'h0000_0005, 32'h0000_0005, 32'h0000_000A, 1'b0});
        vecs.push_back('{CLZ,    32'h0000_0000, 32'h0000_0000, 32'd32,        1'b0});
        vecs.push_back('{CTZ,    32'h0000_0000, 32'h0000_0000, 32'd32,        1'b0});
        vecs.push_back('{CPOP,   32'h0000_0000, 32'h0000_0000, 32'd0,         1'b0});
        vecs.push_back('{CLZ,    32'h00F0_0080, 32'h1234_5678, 32'd8,         1'b0});
        vecs.push_back('{CTZ,    32'h00F0_0080, 32'h1234_5678, 32'd7,         1'b0});
        vecs.push_back('{CPOP,   32'h00F0_0080, 32'h1234_5678, 32'd5,         1'b0});
        vecs.push_back('{SEXTB,  32'h00F0_0080, 32'h0000_0000, 32'hFFFF_FF80, 1'b0});
        vecs.push_back('{SEXTH,  32'h0000_8000, 32'h0000_0000, 32'hFFFF_8000, 1'b0});
        vecs.push_back('{ZEXTH,  32'h00F0_0080, 32'h0000_0000, 32'h0000_0080, 1'b0});
        vecs.push_back('{REV8,   32'h00F0_0080, 32'h0000_0000, 32'h8000_F000, 1'b0});
        vecs.push_back('{ORCB,   32'h00F0_0080, 32'h0000_0000, 32'h00FF_00FF, 1'b0});
        vecs.push_back('{fu_op_t'(6'd40), 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0});

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d %s result", i, vecs[i].op.name()), result, vecs[i].res);
            check($sformatf("vec%0d %s branch", i, vecs[i].op.name()), 32'(br), 32'(vecs[i].br));
        end

        // Reset must not disturb a purely combinational result.
        apply(LTS, 32'hFFFF_FFFF, 32'h0000_0002);
        model(LTS, 32'hFFFF_FFFF, 32'h0000_0002, exp_r, exp_b);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rst-high cycle%0d result", c), result, exp_r);
            check($sformatf("rst-high cycle%0d branch", c), 32'(br), 32'(exp_b));
        end
        rst = 1'b0;
        @(negedge clk);
        check("rst-release result", result, exp_r);
        check("rst-release branch", 32'(br), 32'(exp_b));

        // Zero latency: a new operand is visible before the next clock edge.
        apply(ADD, 32'h0000_0010, 32'h0000_0020);
        fu_data.operand_b = 32'h0000_0001;
        #1;
        check("same-cycle update result", result, 32'h0000_0011);

        for (int i = 0; i < 600; i++) begin
            rop = fu_op_t'($urandom_range(0, 39));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 4))
                0: rb = ra;
                1: begin ra = ra & 32'h0000_00FF; rb = rb & 32'h0000_003F; end
                2: ra = ra & (32'hFFFF_FFFF << $urandom_range(0, 31));
                3: ra = {ra[31], 31'h0} | (ra >> $urandom_range(0, 31));
                default: ;
            endcase
            apply(rop, ra, rb);
            model(rop, ra, rb, exp_r, exp_b);
            check($sformatf("rnd%0d op%0d a=%08h b=%08h result", i, int'(rop), ra, rb), result, exp_r);
            check($sformatf("rnd%0d op%0d a=%08h b=%08h branch", i, int'(rop), ra, rb),
                  32'(br), 32'(exp_b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
